prbs31_rx_checker: RTL

Fabric-side PRBS-31 pattern checker for the far end of a GTY link whose transmitter is an IBERT channel sending PRBS-31. It sits on the user RX datapath after the GT RX gearbox. It self-synchronises to the incoming stream, declares and drops lock, and accumulates bit-error, word and lock-loss statistics. These are read by the 100G Ethernet bring-up tests.

---
 rtl/prbs31_rx_checker.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/prbs31_rx_checker.sv
// prbs31_rx_checker
// Fabric-side PRBS-31 (x^31 + x^28 + 1) checker for a GT RX user datapath.
// It self-synchronises to the incoming stream, declares and drops lock, and
// accumulates bit-error, checked-word and lock-loss statistics.
//
// Ports
//   clk             : GT RX user clock
//   rst_n           : asynchronous active-low reset
//   rx_data_i       : received word, bit 0 first in time
//   rx_valid_i      : qualifies rx_data_i; gaps allowed
//   clear_i         : synchronous clear of all statistics counters
//   locked_o        : checker is in LOCKED
//   err_pulse_o     : one-cycle pulse per errored word while locked
//   bit_err_cnt_o   : saturating errored-bit count
//   word_cnt_o      : saturating count of words checked while locked
//   lock_loss_cnt_o : saturating count of LOCKED -> SEARCH transitions
//
// state  | meaning
// SEARCH | seeding history from received data, waiting for a first match
// VERIFY | counting consecutive matching words towards lock
// LOCKED | free-running generator, errors counted, lock dropped on a burst
module prbs31_rx_checker #(
  parameter int DATA_WIDTH  = 64,
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_WIDTH   = 48,
  parameter int INVERT      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                 rx_valid_i,
  input  logic                 clear_i,
  output logic                 locked_o,
  output logic                 err_pulse_o,
  output logic [CNT_WIDTH-1:0] bit_err_cnt_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o,
  output logic [15:0]          lock_loss_cnt_o
);

  localparam int PCW = $clog2(DATA_WIDTH + 1);
  localparam int SW  = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;
  localparam logic [DATA_WIDTH-1:0] INV_MASK =
    (INVERT != 0) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  // hist[0] is the oldest bit, hist[30] the most recent
  function automatic logic [DATA_WIDTH-1:0] prbs_next(input logic [30:0] h);
    logic [DATA_WIDTH+30:0] s;
    s = '0;
    s[30:0] = h;
    for (int k = 0; k < DATA_WIDTH; k++) s[k+31] = s[k] ^ s[k+3];
    return s[DATA_WIDTH+30:31];
  endfunction

  function automatic logic [PCW-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) c = c + PCW'(v[i]);
    return c;
  endfunction

  state_t                state;
  logic [30:0]           hist;
  logic                  hist_ok;
  logic [7:0]            good;
  logic [7:0]            bad;
  logic                  acc_word;
  logic                  acc_err;
  logic                  acc_loss;
  logic [DATA_WIDTH-1:0] err_vec_q;

  logic [DATA_WIDTH-1:0] gen_word;
  logic [DATA_WIDTH-1:0] err_vec;
  logic                  mismatch;
  logic                  pre_match;
  logic [30:0]           rx_hist;
  logic [30:0]           gen_hist;
  logic [PCW-1:0]        err_pop;
  logic [SW-1:0]         bit_sum;

  always_comb begin
    gen_word  = prbs_next(hist);
    err_vec   = rx_data_i ^ gen_word ^ INV_MASK;
    mismatch  = |err_vec;
    // an idle line (all-zero, or all-one when inverted) must never seed a lock
    pre_match = !mismatch && (rx_data_i != INV_MASK);
    // history is kept in the true (non-inverted) sequence domain
    rx_hist   = rx_data_i[DATA_WIDTH-1 -: 31] ^ INV_MASK[DATA_WIDTH-1 -: 31];
    gen_hist  = gen_word[DATA_WIDTH-1 -: 31];
    err_pop   = popcount(err_vec_q);
    bit_sum   = SW'(bit_err_cnt_o) + SW'(err_pop);
  end

  // Stage 1: state, history and accumulate flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      hist      <= '0;
      hist_ok   <= 1'b0;
      good      <= '0;
      bad       <= '0;
      locked_o  <= 1'b0;
      acc_word  <= 1'b0;
      acc_err   <= 1'b0;
      acc_loss  <= 1'b0;
      err_vec_q <= '0;
    end else begin
      acc_word  <= 1'b0;
      acc_err   <= 1'b0;
      acc_loss  <= 1'b0;
      err_vec_q <= '0;
      if (rx_valid_i) begin
        case (state)
          SEARCH: begin
            hist    <= rx_hist;
            hist_ok <= 1'b1;
            if (hist_ok && pre_match) begin
              if (LOCK_COUNT == 1) begin
                state    <= LOCKED;
                locked_o <= 1'b1;
                bad      <= '0;
              end else begin
                state <= VERIFY;
              end
              good <= 8'd1;
            end
          end
          VERIFY: begin
            hist <= rx_hist;
            if (pre_match) begin
              good <= good + 8'd1;
              if (good == 8'(LOCK_COUNT - 1)) begin
                state    <= LOCKED;
                locked_o <= 1'b1;
                bad      <= '0;
              end
            end else begin
              state <= SEARCH;
              good  <= '0;
            end
          end
          LOCKED: begin
            acc_word <= 1'b1;
            hist     <= gen_hist;
            if (mismatch) begin
              acc_err   <= 1'b1;
              err_vec_q <= err_vec;
              if (bad == 8'(UNLOCK_ERRS - 1)) begin
                state    <= SEARCH;
                locked_o <= 1'b0;
                acc_loss <= 1'b1;
                hist     <= rx_hist;
                hist_ok  <= 1'b1;
                bad      <= '0;
                good     <= '0;
              end else begin
                bad <= bad + 8'd1;
              end
            end else begin
              bad <= '0;
            end
          end
          default: begin
            state    <= SEARCH;
            locked_o <= 1'b0;
          end
        endcase
      end
    end
  end

  // Stage 2: statistics; clear takes priority over a coincident increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_o     <= 1'b0;
      bit_err_cnt_o   <= '0;
      word_cnt_o      <= '0;
      lock_loss_cnt_o <= '0;
    end else begin
      err_pulse_o <= acc_err;
      if (clear_i) begin
        bit_err_cnt_o   <= '0;
        word_cnt_o      <= '0;
        lock_loss_cnt_o <= '0;
      end else begin
        if (acc_err)
          bit_err_cnt_o <= (bit_sum > SW'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_WIDTH-1:0];
        if (acc_word && (word_cnt_o != CNT_MAX))
          word_cnt_o <= word_cnt_o + CNT_WIDTH'(1);
        if (acc_loss && (lock_loss_cnt_o != 16'hFFFF))
          lock_loss_cnt_o <= lock_loss_cnt_o + 16'd1;
      end
    end
  end

endmodule
